shared_reg_arbiter: RTL and testbench

Round-robin arbiter and write sequencer that shares one enable-gated register (`simple_module`: `clk`, `en`, `d`, `q`) among N requesters. It accepts single-word write requests, drives the register's `en`/`d` for exactly one cycle per grant, reads `q` back the following cycle and returns a per-requester ack with the readback value and a mismatch flag. It sits between requester logic and the `simple_module` instance, which it owns exclusively.

---
 rtl/shared_reg_arbiter.sv | 145 ++++++++++++++
 tb/tb_shared_reg_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter that owns one enable-gated register,
// performs one write per grant, reads it back and acks the requester.
`default_nettype none

module shared_reg_arbiter #(
    parameter int N = 4,
    parameter int W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   wdata,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
    output logic [W-1:0]     rdata,
    output logic             err,
    output logic             busy,
    output logic             reg_en,
    output logic [W-1:0]     reg_d,
    input  logic [W-1:0]     reg_q
);

    localparam int             PW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0]    NUM  = (PW+1)'(N);
    localparam logic [PW-1:0]  LAST = PW'(N - 1);
    localparam logic [N-1:0]   ONE  = N'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [N-1:0]    mask, mask_n;
    logic [N-1:0]    gnt_n, ack_n;
    logic            busy_n, reg_en_n;
    logic [W-1:0]    reg_d_n, wbuf, wbuf_n, hold, hold_n;

    logic [N-1:0]    elig;
    logic            found;
    logic [PW-1:0]   win;
    logic [PW:0]     idx;

    // First eligible requester searching upward from ptr, wrapping at N-1.
    always_comb begin
        elig  = req & ~mask;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= NUM) begin
                idx = idx - NUM;
            end
            if (!found && elig[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        mask_n   = mask;
        gnt_n    = gnt;
        ack_n    = ack;
        busy_n   = busy;
        reg_en_n = reg_en;
        reg_d_n  = reg_d;
        wbuf_n   = wbuf;
        hold_n   = hold;
        case (state)
            IDLE: begin
                mask_n = '0;
                if (found) begin
                    state_n  = WRITE;
                    gnt_n    = ONE << win;
                    reg_en_n = 1'b1;
                    reg_d_n  = wdata[win*W +: W];
                    wbuf_n   = wdata[win*W +: W];
                    ptr_n    = (win == LAST) ? '0 : win + PW'(1);
                    busy_n   = 1'b1;
                end
            end
            WRITE: begin
                state_n  = CHECK;
                gnt_n    = '0;
                reg_en_n = 1'b0;
                ack_n    = gnt;
            end
            CHECK: begin
                state_n = IDLE;
                ack_n   = '0;
                busy_n  = 1'b0;
                // Keep the just-served requester out of the next arbitration only.
                mask_n  = ack;
                hold_n  = reg_q;
            end
            default: begin
                state_n  = IDLE;
                gnt_n    = '0;
                ack_n    = '0;
                busy_n   = 1'b0;
                reg_en_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            mask   <= '0;
            gnt    <= '0;
            ack    <= '0;
            busy   <= 1'b0;
            reg_en <= 1'b0;
            reg_d  <= '0;
            wbuf   <= '0;
            hold   <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            mask   <= mask_n;
            gnt    <= gnt_n;
            ack    <= ack_n;
            busy   <= busy_n;
            reg_en <= reg_en_n;
            reg_d  <= reg_d_n;
            wbuf   <= wbuf_n;
            hold   <= hold_n;
        end
    end

    // The register only updates at the edge entering CHECK, so the readback
    // is taken straight from its flop output during CHECK and held afterwards.
    assign rdata = (state == CHECK) ? reg_q : hold;
    assign err   = (state == CHECK) && (reg_q != wbuf);

endmodule

`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed table, corner-case sequences and randomized
// comparison against a transaction-level model for shared_reg_arbiter (N=4, W=1).
`default_nettype none

module tb_shared_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'hf;
    logic [3:0] wdata = 4'h0;
    logic [3:0] gnt, ack;
    logic       rdata, err, busy, reg_en, reg_d, reg_q;
    logic       q_store = 1'b0;
    logic       stuck = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Behaviour of the shared simple_module register, with a stuck-at-0 readback option.
    always @(posedge clk) if (reg_en) q_store <= reg_d;
    assign reg_q = stuck ? 1'b0 : q_store;

    shared_reg_arbiter #(.N(4), .W(1)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
        .reg_en(reg_en), .reg_d(reg_d), .reg_q(reg_q)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One complete transaction, starting at an IDLE-cycle negedge.
    task automatic txn(input logic [3:0] r, input logic [3:0] wd, input logic [3:0] eg,
                       input logic ed, input logic erd, input logic eerr);
        req   = r;
        wdata = wd;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (gnt != 4'h0) break;
        end
        chk("txn_gnt", gnt, eg);
        chk("txn_reg_en", reg_en, 1);
        chk("txn_reg_d", reg_d, ed);
        @(negedge clk);
        chk("txn_ack", ack, eg);
        chk("txn_rdata", rdata, erd);
        chk("txn_err", err, eerr);
        chk("txn_en_low", {gnt, reg_en}, 0);
        req = 4'h0;
        @(negedge clk);
        chk("txn_idle", {ack, err, busy, reg_en}, 0);
        chk("txn_hold", rdata, erd);
    endtask

    typedef struct {
        logic [3:0] r;
        logic [3:0] wd;
        logic [3:0] eg;
        logic       ed;
    } vec_t;
    vec_t tbl [6];

    // Transaction-level reference: m_left counts remaining busy cycles (2 = write, 1 = readback).
    int         m_left, m_win, m_ptr;
    logic [3:0] m_mask;
    logic       m_wbuf, m_reg, m_hold, m_regd;

    task automatic model_step(input logic r_rst, input logic [3:0] r_req, input logic [3:0] r_wd);
        logic [3:0] el;
        if (m_left == 2) m_reg = m_wbuf;
        if (r_rst) begin
            m_left = 0; m_ptr = 0; m_mask = 4'h0; m_hold = 1'b0; m_regd = 1'b0; m_wbuf = 1'b0;
        end else if (m_left == 0) begin
            el     = r_req & ~m_mask;
            m_mask = 4'h0;
            if (el != 4'h0) begin
                for (int k = 0; k < 4; k++) begin
                    if (el[(m_ptr + k) % 4]) begin
                        m_win = (m_ptr + k) % 4;
                        break;
                    end
                end
                m_left = 2;
                m_wbuf = r_wd[m_win];
                m_regd = m_wbuf;
                m_ptr  = (m_win + 1) % 4;
            end
        end else if (m_left == 2) begin
            m_left = 1;
        end else begin
            m_left = 0;
            m_mask = 4'b0001 << m_win;
            m_hold = stuck ? 1'b0 : m_reg;
        end
    endtask

    function automatic logic [12:0] model_out();
        logic [3:0] eg, ea;
        logic       rd, er;
        eg = (m_left == 2) ? (4'b0001 << m_win) : 4'h0;
        ea = (m_left == 1) ? (4'b0001 << m_win) : 4'h0;
        rd = (m_left == 1) ? (stuck ? 1'b0 : m_reg) : m_hold;
        er = (m_left == 1) && (rd != m_wbuf);
        return {eg, ea, rd, er, m_left != 0, m_left == 2, m_regd};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0100, 4'b0100, 4'b0100, 1'b1};
        tbl[1] = '{4'b0011, 4'b0001, 4'b0001, 1'b1};
        tbl[2] = '{4'b0011, 4'b0000, 4'b0010, 1'b0};
        tbl[3] = '{4'b1000, 4'b1000, 4'b1000, 1'b1};
        tbl[4] = '{4'b1110, 4'b0100, 4'b0010, 1'b0};
        tbl[5] = '{4'b0101, 4'b0001, 4'b0100, 1'b0};

        // Reset with all requesters active, then the first grant goes to 0.
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_en_d", {reg_en, reg_d}, 0);
        chk("rst_rdata_err", {rdata, err}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        txn(4'hf, 4'b1010, 4'b0001, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            txn(tbl[i].r, tbl[i].wd, tbl[i].eg, tbl[i].ed, tbl[i].ed, 1'b0);
        end

        // Readback error with the register output stuck at 0.
        stuck = 1'b1;
        txn(4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1);
        stuck = 1'b0;

        // Round-robin with all requests held continuously.
        rst = 1'b1; req = 4'h0;
        @(negedge clk);
        rst = 1'b0; req = 4'hf; wdata = 4'b0101;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c % 3 == 0) begin
                chk("rr_gnt", gnt, 4'b0001 << ((c / 3) % 4));
                chk("rr_reg_d", reg_d, wdata[(c / 3) % 4]);
            end else if (c % 3 == 1) begin
                chk("rr_ack", ack, 4'b0001 << ((c / 3) % 4));
                chk("rr_rdata", rdata, wdata[(c / 3) % 4]);
            end else begin
                chk("rr_idle", {gnt, busy}, 0);
                if (c == 14) req = 4'h0;
            end
        end

        // Pointer rotation and the one-cycle mask gap.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        txn(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0);
        req = 4'b1001; wdata = 4'b1001;
        @(negedge clk); chk("rot_gnt3", gnt, 4'b1000);
        @(negedge clk); chk("rot_ack3", ack, 4'b1000); req = 4'b0001;
        @(negedge clk); chk("rot_idle1", gnt, 0);
        @(negedge clk); chk("rot_gnt0", gnt, 4'b0001);
        @(negedge clk); chk("rot_ack0", ack, 4'b0001);
        @(negedge clk); chk("rot_idle2", {gnt, busy}, 0);
        @(negedge clk); chk("rot_masked_idle", {gnt, busy}, 0);
        @(negedge clk); chk("rot_regrant0", gnt, 4'b0001); req = 4'h0;
        @(negedge clk); chk("rot_ack0b", ack, 4'b0001);
        @(negedge clk);

        // Reset during WRITE: no ack, pointer back to 0.
        req = 4'b0100; wdata = 4'b0100;
        @(negedge clk); chk("rw_gnt", gnt, 4'b0100); rst = 1'b1;
        @(negedge clk); chk("rw_cleared", {gnt, ack, busy, reg_en}, 0);
        rst = 1'b0; req = 4'hf;
        @(negedge clk); chk("rw_ptr0", gnt, 4'b0001); req = 4'h0;
        @(negedge clk); chk("rw_ack_noabort", ack, 4'b0001);
        @(negedge clk);

        // Randomized run against the reference model.
        rst = 1'b1; req = 4'h0; wdata = 4'h0; stuck = 1'b0;
        m_reg = q_store; m_left = 0; m_win = 0;
        model_step(1'b1, 4'h0, 4'h0);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            chk("random", {gnt, ack, rdata, err, busy, reg_en, reg_d}, model_out());
            rst   = ($urandom_range(0, 39) == 0);
            req   = 4'($urandom_range(0, 15));
            wdata = 4'($urandom_range(0, 15));
            if (m_left == 0) stuck = ($urandom_range(0, 3) == 0);
            model_step(rst, req, wdata);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
